// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone classic arbiter: round-robin grant of one shared slave port,
// with a watchdog that ends hung strobes by returning err to the bus owner.
module wb_arbiter_2m #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int SEL_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [SEL_W-1:0]  s_sel_o,
  output logic [DATA_W-1:0] s_dat_o,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  output logic [1:0]        gnt_o,
  output logic              dbg_state
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Handshake: a master owns the slave from the edge its grant registers until the
  // edge after it drops cyc; ack/err reach only the owner, and only while BUSY.
  state_t          state, state_n;
  logic            owner, owner_n;
  logic            last, last_n;
  logic [1:0]      gnt_n;
  logic [WD_W-1:0] wdog, wdog_n;

  logic              owner_cyc, owner_stb, owner_we;
  logic [ADDR_W-1:0] owner_adr;
  logic [SEL_W-1:0]  owner_sel;
  logic [DATA_W-1:0] owner_dat;
  logic              fire;
  logic              pick;

  assign owner_cyc = owner ? m1_cyc_i : m0_cyc_i;
  assign owner_stb = owner ? m1_stb_i : m0_stb_i;
  assign owner_we  = owner ? m1_we_i  : m0_we_i;
  assign owner_adr = owner ? m1_adr_i : m0_adr_i;
  assign owner_sel = owner ? m1_sel_i : m0_sel_i;
  assign owner_dat = owner ? m1_dat_i : m0_dat_i;
  assign fire      = (state == BUSY) && (wdog == WD_LIMIT);
  // Contention goes to the master that did not own the bus last.
  assign pick      = (m0_cyc_i && m1_cyc_i) ? ~last : m1_cyc_i;
  assign dbg_state = (state == BUSY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      gnt_o <= 2'b00;
      wdog  <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last  <= last_n;
      gnt_o <= gnt_n;
      wdog  <= wdog_n;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    gnt_n   = gnt_o;
    wdog_n  = '0;
    case (state)
      IDLE: begin
        if (m0_cyc_i || m1_cyc_i) begin
          state_n = BUSY;
          owner_n = pick;
          gnt_n   = pick ? 2'b10 : 2'b01;
        end
      end
      BUSY: begin
        if (!owner_cyc) begin
          state_n = IDLE;
          last_n  = owner;
          gnt_n   = 2'b00;
        end else if (!fire && owner_stb && !s_ack_i && !s_err_i) begin
          wdog_n = wdog + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    if (state == BUSY) begin
      // A watchdog expiry withdraws the cycle from the slave for that one clock.
      s_cyc_o  = owner_cyc && !fire;
      s_stb_o  = owner_stb && !fire;
      s_we_o   = owner_we;
      s_adr_o  = owner_adr;
      s_sel_o  = owner_sel;
      s_dat_o  = owner_dat;
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
      if (owner) begin
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i || fire;
      end else begin
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i || fire;
      end
    end
  end

endmodule
